mdu_iter: RTL and testbench



---
 rtl/mdu_iter_pkg.sv | 50 +++++
 rtl/mdu_div_step.sv | 28 ++
 rtl/mdu_iter.sv | 175 +++++++++++++++++
 tb/tb_mdu_iter.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/mdu_iter_pkg.sv
// mdu_iter_pkg: shared definitions for the iterative RV32M multiply/divide unit.
// Holds the datapath width, the funct3 operation codes, the FSM state encoding
// and small helpers for operand signedness and magnitude conversion.
package mdu_iter_pkg;

  localparam int MDU_W = 32;

  // RV32M funct3 codes
  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_CALC = 2'd1,
    MDU_FIX  = 2'd2,
    MDU_DONE = 2'd3
  } mdu_state_t;

  // Operand A is treated as signed for MUL, MULH, MULHSU, DIV and REM.
  function automatic logic a_is_signed(input logic [2:0] op);
    logic res;
    case (op)
      MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM: res = 1'b1;
      default:                                         res = 1'b0;
    endcase
    return res;
  endfunction

  // Operand B is treated as signed for MUL, MULH, DIV and REM.
  function automatic logic b_is_signed(input logic [2:0] op);
    logic res;
    case (op)
      MDU_MUL, MDU_MULH, MDU_DIV, MDU_REM: res = 1'b1;
      default:                             res = 1'b0;
    endcase
    return res;
  endfunction

  // Two's-complement magnitude of a value already known to be negative or not.
  function automatic logic [MDU_W-1:0] mag32(input logic [MDU_W-1:0] v, input logic neg);
    return neg ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// mdu_div_step: one combinational restoring-division step.
// Ports:
//   rem          in  32  partial remainder before this step
//   dividend_bit in  1   next dividend bit shifted into the remainder
//   divisor      in  32  divisor magnitude
//   rem_next     out 32  partial remainder after this step
//   q_bit        out 1   quotient bit produced by this step
module mdu_div_step
  import mdu_iter_pkg::*;
(
  input  logic [MDU_W-1:0] rem,
  input  logic             dividend_bit,
  input  logic [MDU_W-1:0] divisor,
  output logic [MDU_W-1:0] rem_next,
  output logic             q_bit
);

  logic [MDU_W:0]   shifted_s;
  logic [MDU_W-1:0] diff_s;

  assign shifted_s = {rem, dividend_bit};
  // 33-bit trial subtract: the compare is the borrow-out, the low bits are the
  // difference, which always fits in 32 bits when the subtract succeeds.
  assign q_bit    = (shifted_s >= {1'b0, divisor});
  assign diff_s   = shifted_s[MDU_W-1:0] - divisor;
  assign rem_next = q_bit ? diff_s : shifted_s[MDU_W-1:0];

endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV32M multiply/divide unit with start/busy/done handshake.
// Multiply is radix-2 shift-add over a 64-bit accumulator; divide is restoring
// division. Both run 32 CALC steps, then a FIX cycle applies sign correction.
// Division by zero and signed overflow bypass CALC/FIX and finish in one cycle.
// Ports:
//   clk    in  1     clock, rising edge
//   rst_n  in  1     asynchronous active-low reset
//   start  in  1     request, sampled only in IDLE or DONE
//   flush  in  1     synchronous abort, highest priority
//   op     in  3     RV32M funct3
//   opA    in  XLEN  operand A (rD1)
//   opB    in  XLEN  operand B (ALU_B path)
//   busy   out 1     operation in flight
//   done   out 1     one-cycle completion pulse
//   result out XLEN  registered result, held until the next done
module mdu_iter
  import mdu_iter_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] opA,
  input  logic [XLEN-1:0] opB,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  mdu_state_t  state_r, state_nxt_s;
  logic [2:0]  op_r;
  logic        a_neg_r, b_neg_r;
  logic [31:0] b_mag_r;
  logic [63:0] acc_r;
  logic [4:0]  cnt_r;
  logic [31:0] result_r;
  logic        busy_r, done_r, busy_nxt_s, done_nxt_s;

  logic        ready_s, accept_s, a_neg_s, b_neg_s, fast_s;
  logic [31:0] a_mag_s, b_mag_s, fast_res_s, fix_res_s;
  logic [32:0] mul_sum_s;
  logic [63:0] acc_step_s, prod_s;
  logic [31:0] div_rem_s, quo_s, rem_s;
  logic        div_q_s;

  assign ready_s  = (state_r == MDU_IDLE) || (state_r == MDU_DONE);
  assign accept_s = ready_s && start && !flush;
  assign a_neg_s  = a_is_signed(op) & opA[31];
  assign b_neg_s  = b_is_signed(op) & opB[31];
  assign a_mag_s  = mag32(opA, a_neg_s);
  assign b_mag_s  = mag32(opB, b_neg_s);

  // Fast-path detection on the raw request operands
  always_comb begin
    fast_s     = 1'b0;
    fast_res_s = 32'd0;
    if (op[2] && (opB == 32'd0)) begin
      fast_s     = 1'b1;
      fast_res_s = op[1] ? opA : 32'hFFFF_FFFF;
    end else if (op[2] && !op[0] && (opA == 32'h8000_0000) && (opB == 32'hFFFF_FFFF)) begin
      fast_s     = 1'b1;
      fast_res_s = op[1] ? 32'd0 : 32'h8000_0000;
    end else begin
      fast_s     = 1'b0;
      fast_res_s = 32'd0;
    end
  end

  // Divide accumulator layout: acc_r[63:32] remainder, acc_r[31:0] dividend
  // bits shifting out at the top while quotient bits shift in at the bottom.
  mdu_div_step u_div_step (
    .rem          (acc_r[63:32]),
    .dividend_bit (acc_r[31]),
    .divisor      (b_mag_r),
    .rem_next     (div_rem_s),
    .q_bit        (div_q_s)
  );

  // Multiply accumulator: add multiplicand to the high half when the
  // multiplier LSB is set, then shift the whole 65-bit sum right by one.
  assign mul_sum_s  = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, b_mag_r} : 33'd0);
  assign acc_step_s = op_r[2] ? {div_rem_s, acc_r[30:0], div_q_s}
                              : {mul_sum_s, acc_r[31:1]};

  // Sign correction and result select for the FIX cycle
  always_comb begin
    prod_s    = (a_neg_r ^ b_neg_r) ? (64'd0 - acc_r) : acc_r;
    quo_s     = (a_neg_r ^ b_neg_r) ? (32'd0 - acc_r[31:0]) : acc_r[31:0];
    rem_s     = a_neg_r ? (32'd0 - acc_r[63:32]) : acc_r[63:32];
    fix_res_s = 32'd0;
    case (op_r)
      MDU_MUL:                          fix_res_s = prod_s[31:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU:  fix_res_s = prod_s[63:32];
      MDU_DIV, MDU_DIVU:                fix_res_s = quo_s;
      MDU_REM, MDU_REMU:                fix_res_s = rem_s;
      default:                          fix_res_s = 32'd0;
    endcase
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    state_nxt_s = MDU_IDLE;
    if (flush) begin
      state_nxt_s = MDU_IDLE;
    end else begin
      case (state_r)
        MDU_IDLE: state_nxt_s = start ? (fast_s ? MDU_DONE : MDU_CALC) : MDU_IDLE;
        MDU_CALC: state_nxt_s = (cnt_r == 5'd31) ? MDU_FIX : MDU_CALC;
        MDU_FIX:  state_nxt_s = MDU_DONE;
        MDU_DONE: state_nxt_s = start ? (fast_s ? MDU_DONE : MDU_CALC) : MDU_IDLE;
        default:  state_nxt_s = MDU_IDLE;
      endcase
    end
  end

  // Output decode from the next state so busy/done come straight from flops
  always_comb begin
    busy_nxt_s = (state_nxt_s == MDU_CALC) || (state_nxt_s == MDU_FIX);
    done_nxt_s = (state_nxt_s == MDU_DONE);
  end

  // State and handshake output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= MDU_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= busy_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

  // Operand capture and CALC iteration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r    <= 3'd0;
      a_neg_r <= 1'b0;
      b_neg_r <= 1'b0;
      b_mag_r <= 32'd0;
      acc_r   <= 64'd0;
      cnt_r   <= 5'd0;
    end else if (accept_s) begin
      op_r    <= op;
      a_neg_r <= a_neg_s;
      b_neg_r <= b_neg_s;
      b_mag_r <= b_mag_s;
      acc_r   <= {32'd0, a_mag_s};
      cnt_r   <= 5'd0;
    end else if ((state_r == MDU_CALC) && !flush) begin
      acc_r   <= acc_step_s;
      cnt_r   <= cnt_r + 5'd1;
    end
  end

  // Result register: written by the fast path at accept or by FIX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_r <= 32'd0;
    end else if (accept_s && fast_s) begin
      result_r <= fast_res_s;
    end else if ((state_r == MDU_FIX) && !flush) begin
      result_r <= fix_res_s;
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed self-checking bench for mdu_iter.
module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] opA = 32'd0;
  logic [31:0] opB = 32'd0;
  logic        busy, done;
  logic [31:0] result;

  int pass_cnt = 0;
  int total_cnt = 0;
  int edges, busy_cnt, extra_done;

  mdu_iter #(.XLEN(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .flush  (flush),
    .op     (op),
    .opA    (opA),
    .opB    (opB),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  // Drive a one-cycle start; returns at the negedge just after the accepting edge T.
  task automatic launch(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op = o; opA = a; opB = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // e = number of rising edges after T before done is seen (done in cycle T+e..T+e+1);
  // bc = number of sampled cycles with busy high before done.
  task automatic wait_done(input string tag, output int e, output int bc);
    e = 0; bc = 0;
    while (done !== 1'b1 && e < 100) begin
      if (busy === 1'b1) bc++;
      @(negedge clk);
      e++;
    end
    check({tag, "_done_seen"}, {31'd0, done}, 32'd1);
  endtask

  task automatic run(input string tag, input logic [2:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp_res, input int exp_e);
    launch(o, a, b);
    wait_done(tag, edges, busy_cnt);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_latency"}, edges, exp_e);
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // MUL 7 * -3 with busy duration
    launch(3'b000, 32'd7, 32'hFFFF_FFFD);
    wait_done("mul", edges, busy_cnt);
    check("mul_result", result, 32'hFFFF_FFEB);
    check("mul_latency", edges, 33);
    check("mul_busy_cycles", busy_cnt, 33);
    check("mul_busy_in_done", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("mul_done_pulse", {31'd0, done}, 32'd0);

    // High-half multiplies
    run("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    run("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);

    // Divide / remainder, signed and unsigned
    run("div",  3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run("rem",  3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run("divu", 3'b101, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 33);
    run("remu", 3'b111, 32'hFFFF_FFF9, 32'd2, 32'd1, 33);
    run("div_pos", 3'b100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 33);

    // Fast path: done in the cycle right after the accepting edge
    run("divu_by0", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
    run("rem_by0",  3'b110, 32'd5, 32'd0, 32'd5, 0);
    run("div_ovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    run("rem_ovf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);

    // start during CALC is ignored and not queued
    launch(3'b000, 32'd3, 32'd4);
    repeat (9) @(negedge clk);
    op = 3'b101; opA = 32'd100; opB = 32'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ign", edges, busy_cnt);
    check("ign_result", result, 32'd12);
    check("ign_latency", edges + 10, 33);
    @(negedge clk);
    check("ign_not_queued_busy", {31'd0, busy}, 32'd0);
    check("ign_not_queued_done", {31'd0, done}, 32'd0);

    // Back-to-back: start during DONE
    launch(3'b000, 32'd3, 32'd5);
    wait_done("b2b_first", edges, busy_cnt);
    check("b2b_first_result", result, 32'd15);
    op = 3'b101; opA = 32'd100; opB = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy_contig", {31'd0, busy}, 32'd1);
    check("b2b_done_low", {31'd0, done}, 32'd0);
    wait_done("b2b_second", edges, busy_cnt);
    check("b2b_second_result", result, 32'd14);
    check("b2b_second_latency", edges, 33);
    @(negedge clk);

    // Flush at cycle 10
    launch(3'b101, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_done", {31'd0, done}, 32'd0);
    check("flush_result_held", result, 32'd14);
    extra_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) extra_done++;
    end
    check("flush_no_done", extra_done, 0);
    check("flush_result_still", result, 32'd14);

    // Asynchronous reset mid-divide
    launch(3'b100, 32'd100, 32'd7);
    repeat (19) @(negedge clk);
    check("rst_mid_busy_before", {31'd0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_done", {31'd0, done}, 32'd0);
    check("rst_mid_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run("mul_after_rst", 3'b000, 32'd3, 32'd4, 32'd12, 33);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
